// File: rtl/apb_qspi_host_bridge.sv
// apb_qspi_host_bridge: APB completer that forwards each 32-bit access as one
// quad-SPI frame to a remote device-side management bridge (mode 0, nibble-wide).
// Optional: QSPI_HOST_POSTED_WRITE_EN completes valid writes immediately and
// runs their frame in the background; later accesses wait for IDLE.
module apb_qspi_host_bridge #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter int unsigned ADDR_WIDTH   = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  input  logic [3:0]            pstrb,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  qspi_sck,
  output logic                  qspi_cs_n,
  output logic [3:0]            qspi_dq_out,
  output logic [3:0]            qspi_dq_oe,
  input  logic [3:0]            qspi_dq_in,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [5:0] LAST_W   = 6'd15;
  localparam logic [5:0] LAST_R   = 6'(15 + DUMMY_CYCLES);
  localparam logic [5:0] RD_START = 6'(8 + DUMMY_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_SETUP, S_OPCODE, S_ADDR, S_WDATA,
    S_TURN, S_RDATA, S_CS_HOLD, S_CS_IDLE, S_DONE
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            half_q;
  logic [5:0]      nib_q;
  logic [63:0]     tx_q;
  logic [31:0]     rx_q;
  logic            write_q;
  logic            posted_q;
  logic [31:0]     prdata_q;
  logic            pready_q, pslverr_q, sck_q, cs_n_q;
  logic [3:0]      dq_out_q, dq_oe_q;

  logic [23:0]     addr24_d;
  logic            err_d;
  logic [63:0]     frame_d;
  logic [5:0]      nib_d;
  logic [5:0]      last_nib_d;

  // Frame image and access validation for the cycle an access is accepted
  always_comb begin
    addr24_d   = 24'(paddr);
    err_d      = (paddr[1:0] != 2'b00) || (pwrite && (pstrb != 4'hF));
    frame_d    = {(pwrite ? 8'h02 : 8'h03), addr24_d,
                  (pwrite ? {pwdata[7:0], pwdata[15:8], pwdata[23:16], pwdata[31:24]} : 32'h0)};
    nib_d      = nib_q + 6'd1;
    last_nib_d = write_q ? LAST_W : LAST_R;
  end

  // Frame sequencer: every output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= 1'b0;
      nib_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      write_q   <= 1'b0;
      posted_q  <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      dq_out_q  <= '0;
      dq_oe_q   <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (psel && penable) begin
            write_q  <= pwrite;
            tx_q     <= frame_d;
            prdata_q <= '0;
            cnt_q    <= '0;
            half_q   <= 1'b0;
            nib_q    <= '0;
            if (err_d) begin
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              cs_n_q  <= 1'b0;
              state_q <= S_CS_SETUP;
`ifdef QSPI_HOST_POSTED_WRITE_EN
              posted_q <= pwrite;
              pready_q <= pwrite;
`endif
            end
          end
        end
        S_CS_SETUP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            dq_out_q <= tx_q[63:60];
            dq_oe_q  <= 4'hF;
            state_q  <= S_OPCODE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OPCODE, S_ADDR, S_WDATA, S_TURN, S_RDATA: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (!half_q) begin
              // rising edge: link data is stable since the previous falling edge
              half_q <= 1'b1;
              sck_q  <= 1'b1;
              if (state_q == S_RDATA) rx_q <= {rx_q[27:0], qspi_dq_in};
            end else begin
              // falling edge: advance to the next nibble
              half_q   <= 1'b0;
              sck_q    <= 1'b0;
              nib_q    <= nib_d;
              tx_q     <= {tx_q[59:0], 4'h0};
              dq_out_q <= tx_q[59:56];
              if (nib_q == last_nib_d) begin
                dq_out_q <= '0;
                dq_oe_q  <= '0;
                state_q  <= S_CS_HOLD;
                if (!write_q)
                  prdata_q <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
              end else if (nib_d == 6'd2) begin
                state_q <= S_ADDR;
              end else if (nib_d == 6'd8) begin
                if (write_q) begin
                  state_q <= S_WDATA;
                end else begin
                  dq_out_q <= '0;
                  dq_oe_q  <= '0;
                  state_q  <= S_TURN;
                end
              end else if (!write_q && nib_d == RD_START) begin
                state_q <= S_RDATA;
              end
            end
          end
        end
        S_CS_HOLD: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            half_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            state_q <= S_CS_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CS_IDLE: begin
          // two passes of the phase counter give the 2*CLK_DIV deselect time
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (half_q) begin
              half_q   <= 1'b0;
              pready_q <= !posted_q;
              state_q  <= S_DONE;
            end else begin
              half_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          posted_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign qspi_sck    = sck_q;
  assign qspi_cs_n   = cs_n_q;
  assign qspi_dq_out = dq_out_q;
  assign qspi_dq_oe  = dq_oe_q;
  assign busy        = (state_q != S_IDLE);

endmodule
